ahb_slave_responder: RTL and testbench

AHB_SLAVE_RESPONDER -- requirements
Module: ahb_slave_responder

---
 rtl/ahb_slave_responder.sv | 141 ++++++++++++++
 tb/tb_ahb_slave_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_responder.sv
// AHB-Lite byte-wide slave backed by a 2^MEM_AW-byte memory.
// Each in-range transfer is stretched by WAIT_CYCLES wait states. An out-of-range
// address gets the two-cycle ERROR response and never touches memory.
//
// Ports:
//   clk       - single clock, all state on the rising edge
//   rst       - asynchronous active-low reset
//   HSEL      - slave select from the address decoder
//   HADDR     - byte address (bits 14:13 are decoder bits and are ignored)
//   HTRANS    - transfer type; only NONSEQ/SEQ start a transfer
//   HWRITE    - 1 write, 0 read
//   HWDATA    - write data, sampled at the edge that ends the DATA state
//   HREADY    - bus-wide ready; an address phase is taken only when high
//   HRDATA    - read data, non-zero only during a read DATA state
//   HREADYOUT - slave ready, low while the data phase is extended
//   HRESP     - 0 OKAY, 1 ERROR
module ahb_slave_responder #(
  parameter int unsigned MEM_AW      = 11,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSEL,
  input  logic [15:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [7:0]  HWDATA,
  input  logic        HREADY,
  output logic [7:0]  HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int unsigned MemDepth = 1 << MEM_AW;

  // Bits that must be zero for an in-range address: bit 15 plus bits 12..MEM_AW.
  function automatic logic [15:0] calc_range_mask(input int unsigned aw);
    logic [15:0] m;
    m     = '0;
    m[15] = 1'b1;
    for (int unsigned i = 0; i < 13; i++) begin
      if (i >= aw) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [15:0] RangeMask = calc_range_mask(MEM_AW);
  // Last value of the wait counter before moving to DATA; unused when WAIT_CYCLES is 0.
  localparam logic [2:0]  WaitLast  = 3'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e              state_q;
  logic [MEM_AW-1:0]   addr_q;
  logic                write_q;
  logic [2:0]          cnt_q;
  logic [7:0]          mem [MemDepth];

  logic                completing;
  logic                accept;
  logic                out_of_range;
  logic [MEM_AW-1:0]   idx;
  logic                mem_we;
  logic [7:0]          rd_word;

  // New address phases are only taken while this slave is not stretching the bus.
  assign completing   = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
  assign accept       = HSEL && HREADY && (HTRANS inside {2'b10, 2'b11}) && completing;
  assign out_of_range = |(HADDR & RangeMask);
  assign idx          = HADDR[MEM_AW-1:0];
  assign mem_we       = (state_q == StData) && write_q;

  // Zero-wait read right behind a write to the same byte sees the data being written.
  assign rd_word = (mem_we && (addr_q == idx)) ? HWDATA : mem[idx];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= HWDATA;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      write_q   <= 1'b0;
      cnt_q     <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= 8'h00;
    end else begin
      case (state_q)
        StWait: begin
          if (cnt_q == WaitLast) begin
            state_q   <= StData;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= write_q ? 8'h00 : mem[addr_q];
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        StErr1: begin
          state_q   <= StErr2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
          HRDATA    <= 8'h00;
        end
        default: begin
          // IDLE, DATA and ERR2 all complete this cycle and may start the next transfer.
          if (accept) begin
            addr_q  <= idx;
            write_q <= HWRITE;
            if (out_of_range) begin
              state_q   <= StErr1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
              HRDATA    <= 8'h00;
            end else if (WAIT_CYCLES > 0) begin
              state_q   <= StWait;
              cnt_q     <= '0;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b0;
              HRDATA    <= 8'h00;
            end else begin
              state_q   <= StData;
              HREADYOUT <= 1'b1;
              HRESP     <= 1'b0;
              HRDATA    <= HWRITE ? 8'h00 : rd_word;
            end
          end else begin
            state_q   <= StIdle;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= 8'h00;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_slave_responder.sv
// Bench for ahb_slave_responder: three instances (0, 1 and 3 wait states) share one
// bus; one is selected at a time. A byte-array model predicts every response.
module tb_ahb_slave_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel_en;
  logic [1:0]  act;
  logic        stall;
  logic [15:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [7:0]  hwdata;
  logic        hready;
  logic [7:0]  hrd [3];
  logic        hro [3];
  logic        hresp [3];

  ahb_slave_responder #(.MEM_AW(11), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .HSEL(sel_en && act == 2'd0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready), .HRDATA(hrd[0]),
    .HREADYOUT(hro[0]), .HRESP(hresp[0]));
  ahb_slave_responder #(.MEM_AW(11), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .HSEL(sel_en && act == 2'd1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready), .HRDATA(hrd[1]),
    .HREADYOUT(hro[1]), .HRESP(hresp[1]));
  ahb_slave_responder #(.MEM_AW(11), .WAIT_CYCLES(3)) u2 (
    .clk(clk), .rst(rst), .HSEL(sel_en && act == 2'd2), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready), .HRDATA(hrd[2]),
    .HREADYOUT(hro[2]), .HRESP(hresp[2]));

  // Bus ready follows the selected slave unless another master/slave stalls the bus.
  always_comb begin
    hready = 1'b0;
    if (!stall) begin
      case (act)
        2'd0:    hready = hro[0];
        2'd1:    hready = hro[1];
        default: hready = hro[2];
      endcase
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mdl   [3][2048];
  bit         known [3][2048];

  // 2K window: bit 15 and bits 12:11 must be clear, bits 14:13 are don't-care.
  function automatic bit model_oor(input logic [15:0] a);
    return a[15] || ((a % 16'd8192) >= 16'd2048);
  endfunction

  function automatic int wait_of(input int d);
    case (d)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int d);
    check({tag, ":hreadyout"}, 8'(hro[d]), 8'h01);
    check({tag, ":hresp"}, 8'(hresp[d]), 8'h00);
    check({tag, ":hrdata"}, hrd[d], 8'h00);
  endtask

  // One non-pipelined transfer; checks wait count, response and data against the model.
  task automatic xfer(input int d, input logic wr, input logic [15:0] a,
                      input logic [7:0] wd, input string tag);
    bit          oor;
    int          exp_waits;
    int          lows;
    bit          done;
    logic [10:0] ix;
    oor       = model_oor(a);
    exp_waits = oor ? 1 : wait_of(d);
    ix        = a[10:0];
    lows      = 0;
    done      = 1'b0;
    act = 2'(d); sel_en = 1'b1; haddr = a; htrans = 2'b10; hwrite = wr;
    @(posedge clk); #1;
    sel_en = 1'b0; htrans = 2'b00; hwrite = 1'($urandom); haddr = 16'($urandom);
    hwdata = wd;
    for (int c = 0; c < 16 && !done; c++) begin
      @(negedge clk);
      if (hro[d] === 1'b1) begin
        done = 1'b1;
      end else begin
        lows++;
        check({tag, ":wait_resp"}, 8'(hresp[d]), 8'(oor));
        check({tag, ":wait_rdata"}, hrd[d], 8'h00);
      end
    end
    check({tag, ":done"}, 8'(done), 8'h01);
    check({tag, ":waits"}, 8'(lows), 8'(exp_waits));
    check({tag, ":resp"}, 8'(hresp[d]), 8'(oor));
    if (wr || oor) check({tag, ":rdata"}, hrd[d], 8'h00);
    else if (known[d][ix]) check({tag, ":rdata"}, hrd[d], mdl[d][ix]);
    @(posedge clk);
    if (wr && !oor) begin
      mdl[d][ix]   = wd;
      known[d][ix] = 1'b1;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; sel_en = 1'b0; act = 2'd0; stall = 1'b0;
    haddr = '0; htrans = 2'b00; hwrite = 1'b0; hwdata = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_idle("reset", d);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Single write then read-back with one wait state.
    xfer(1, 1'b1, 16'h0010, 8'h5A, "wr_0010");
    xfer(1, 1'b0, 16'h0010, 8'h00, "rd_0010");

    // Zero-wait write immediately followed by a read of the same byte.
    act = 2'd0; sel_en = 1'b1; haddr = 16'h0001; htrans = 2'b10; hwrite = 1'b1;
    @(posedge clk); #1;
    haddr = 16'h0001; htrans = 2'b10; hwrite = 1'b0; hwdata = 8'h11;
    @(negedge clk);
    check_idle("b2b_wr", 0);
    @(posedge clk); #1;
    sel_en = 1'b0; htrans = 2'b00;
    mdl[0][1] = 8'h11; known[0][1] = 1'b1;
    @(negedge clk);
    check("b2b_rd:hreadyout", 8'(hro[0]), 8'h01);
    check("b2b_rd:hresp", 8'(hresp[0]), 8'h00);
    check("b2b_rd:hrdata", hrd[0], 8'h11);
    @(posedge clk); #1;

    // Out-of-range write must not alias onto byte 0.
    xfer(1, 1'b1, 16'h0000, 8'hA5, "pre_0000");
    xfer(1, 1'b1, 16'h1800, 8'h77, "oor_1800");
    xfer(1, 1'b0, 16'h0000, 8'h00, "rd_0000");

    // BUSY while selected, and NONSEQ while unselected: neither is a transfer.
    act = 2'd1; sel_en = 1'b1; haddr = 16'h0010; htrans = 2'b01; hwrite = 1'b1;
    hwdata = 8'hEE;
    repeat (2) begin
      @(posedge clk); #1;
      check_idle("busy", 1);
    end
    sel_en = 1'b0; htrans = 2'b10;
    repeat (2) begin
      @(posedge clk); #1;
      check_idle("unsel", 1);
    end
    htrans = 2'b00;
    @(posedge clk); #1;
    xfer(1, 1'b0, 16'h0010, 8'h00, "rd_after_idle");

    // Valid NONSEQ held while the bus is stalled is taken only once HREADY rises.
    stall = 1'b1;
    act = 2'd1; sel_en = 1'b1; haddr = 16'h0010; htrans = 2'b10; hwrite = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_idle("stalled", 1);
      @(posedge clk);
    end
    #1; stall = 1'b0;
    @(posedge clk); #1;
    sel_en = 1'b0; htrans = 2'b00;
    @(negedge clk);
    check("stall_acc:wait", 8'(hro[1]), 8'h00);
    @(negedge clk);
    check("stall_acc:hreadyout", 8'(hro[1]), 8'h01);
    check("stall_acc:hrdata", hrd[1], 8'h5A);
    @(posedge clk); #1;

    // Reset in the second wait cycle aborts the write.
    xfer(2, 1'b1, 16'h0020, 8'hC3, "pre_0020");
    act = 2'd2; sel_en = 1'b1; haddr = 16'h0020; htrans = 2'b10; hwrite = 1'b1;
    @(posedge clk); #1;
    sel_en = 1'b0; htrans = 2'b00; hwdata = 8'h3C;
    @(negedge clk);
    check("rst_mid:wait1", 8'(hro[2]), 8'h00);
    @(posedge clk); #2;
    check("rst_mid:wait2", 8'(hro[2]), 8'h00);
    rst = 1'b0;
    #1;
    check_idle("rst_mid:async", 2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_mid:after", 2);
    @(posedge clk); #1;
    xfer(2, 1'b0, 16'h0020, 8'h00, "rd_0020");

    // Random single transfers across all three instances.
    for (int i = 0; i < 60; i++) begin
      int          d;
      logic        wr;
      bit          bad;
      logic [15:0] a;
      d   = int'($urandom_range(0, 2));
      wr  = 1'($urandom_range(0, 1));
      bad = ($urandom_range(0, 4) == 0);
      a   = {1'b0, 2'($urandom), bad ? 2'($urandom_range(1, 3)) : 2'b00, 6'b0,
             5'($urandom)};
      xfer(d, wr, a, 8'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
